// File: rtl/xfer_pkg.sv
// rtl/xfer_pkg.sv - shared opcode/state types and strobe constants for the transfer sequencer
package xfer_pkg;

  // Operation codes carried on req_op
  typedef enum logic [2:0] {
    OP_MOVE = 3'd0,
    OP_LDL  = 3'd1,
    OP_LDH  = 3'd2,
    OP_STL  = 3'd3,
    OP_STH  = 3'd4,
    OP_ADDR = 3'd5,
    OP_RSV6 = 3'd6,
    OP_RSV7 = 3'd7
  } xfer_op_t;

  // Sequencer phases: strobes low in DRIVE, loads rise entering HOLD
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_HOLD  = 2'd2
  } xfer_state_t;

  // Widest strobe bank supported; callers slice down to their register count
  localparam int MAX_REGS = 32;
  localparam logic [MAX_REGS-1:0] STROBES_OFF = '1;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter starting its search at the pointer
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PW-1:0]      grant_idx_o
);

  // Scan requesters from ptr_i upward (wrapping) and grant the first valid one
  always_comb begin
    int           cand;
    logic [PW-1:0] ci;
    logic         found;
    cand        = 0;
    ci          = '0;
    found       = 1'b0;
    grant_o     = '0;
    grant_idx_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      ci = cand[PW-1:0];
      if (!found && req_i[ci]) begin
        found       = 1'b1;
        grant_o[ci] = 1'b1;
        grant_idx_o = ci;
      end
    end
    if (!advance_i) grant_o = '0;
  end

endmodule

// File: rtl/xfer_sequencer.sv
// rtl/xfer_sequencer.sv - arbitrates register moves/byte loads/stores and drives the bank strobes
module xfer_sequencer
  import xfer_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int NUM_REQ  = 2,
  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*3-1:0]  req_op,
  input  logic [NUM_REQ*RW-1:0] req_src,
  input  logic [NUM_REQ*RW-1:0] req_dst,
  output logic                  done,
  output logic                  err,
  output logic [IW-1:0]         resp_id,
  output logic [NUM_REGS-1:0]   l_tl_n,
  output logic [NUM_REGS-1:0]   l_th_n,
  output logic [NUM_REGS-1:0]   l_tx_n,
  output logic [NUM_REGS-1:0]   a_tl_n,
  output logic [NUM_REGS-1:0]   a_th_n,
  output logic [NUM_REGS-1:0]   a_tx_addr_n,
  output logic [NUM_REGS-1:0]   a_tx_xfer_n
);

  localparam logic [NUM_REGS-1:0] OFF    = STROBES_OFF[NUM_REGS-1:0];
  localparam logic [NUM_REGS-1:0] BIT0   = NUM_REGS'(1);
  localparam logic [RW:0]         NREGS  = (RW+1)'(NUM_REGS);

  xfer_state_t   state_q;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] gid_q;

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      gidx;
  logic               accept;
  xfer_op_t           op_d;
  logic [RW-1:0]      src_d;
  logic [RW-1:0]      dst_d;
  logic               src_bad, dst_bad, reject_d;
  logic [NUM_REGS-1:0] src_n_d, dst_n_d;
  logic [IW-1:0]      ptr_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .advance_i   (rst_n && (state_q == ST_IDLE)),
    .grant_o     (grant),
    .grant_idx_o (gidx)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  // Decode the granted requester's operation and decide whether it is legal
  always_comb begin
    op_d     = xfer_op_t'(req_op[int'(gidx)*3 +: 3]);
    src_d    = req_src[int'(gidx)*RW +: RW];
    dst_d    = req_dst[int'(gidx)*RW +: RW];
    src_bad  = ({1'b0, src_d} >= NREGS);
    dst_bad  = ({1'b0, dst_d} >= NREGS);
    src_n_d  = ~(BIT0 << src_d);
    dst_n_d  = ~(BIT0 << dst_d);
    ptr_d    = (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
    case (op_d)
      OP_MOVE:                 reject_d = src_bad || dst_bad || (src_d == dst_d);
      OP_LDL, OP_LDH:          reject_d = dst_bad;
      OP_STL, OP_STH, OP_ADDR: reject_d = src_bad;
      default:                 reject_d = 1'b1;
    endcase
  end

  // Sequencer FSM: strobes drop in DRIVE, loads rise entering HOLD, asserts release after HOLD
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gid_q       <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      resp_id     <= '0;
      l_tl_n      <= OFF;
      l_th_n      <= OFF;
      l_tx_n      <= OFF;
      a_tl_n      <= OFF;
      a_th_n      <= OFF;
      a_tx_addr_n <= OFF;
      a_tx_xfer_n <= OFF;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            ptr_q <= ptr_d;
            gid_q <= gidx;
            if (reject_d) begin
              err     <= 1'b1;
              resp_id <= gidx;
            end else begin
              state_q <= ST_DRIVE;
              case (op_d)
                OP_MOVE: begin
                  a_tx_xfer_n <= src_n_d;
                  l_tx_n      <= dst_n_d;
                end
                OP_LDL:  l_tl_n      <= dst_n_d;
                OP_LDH:  l_th_n      <= dst_n_d;
                OP_STL:  a_tl_n      <= src_n_d;
                OP_STH:  a_th_n      <= src_n_d;
                OP_ADDR: a_tx_addr_n <= src_n_d;
                default: ;
              endcase
            end
          end
        end
        ST_DRIVE: begin
          // Rising load strobes latch here while the asserting source keeps driving
          state_q <= ST_HOLD;
          l_tl_n  <= OFF;
          l_th_n  <= OFF;
          l_tx_n  <= OFF;
        end
        ST_HOLD: begin
          state_q     <= ST_IDLE;
          a_tl_n      <= OFF;
          a_th_n      <= OFF;
          a_tx_addr_n <= OFF;
          a_tx_xfer_n <= OFF;
          done        <= 1'b1;
          resp_id     <= gid_q;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/xfer_sequencer.md
Name: xfer_sequencer

Overview:
- Sequences the bank of 16-bit transfer registers. It accepts register-move and byte load/store operations from several requesters and arbitrates them round-robin.
- It generates the per-register active-low strobes (load low/high/xfer, assert low/high/addr/xfer). Each register latches on the rising edge of its load strobe.
- Guarantees a single driver per bus (transfer, address, main) and setup/hold around every latch edge.
- Sits between the pipeline control stages and the transfer register bank.

Parameters:
NUM_REGS, 4, number of transfer registers controlled (index width RW = clog2(NUM_REGS))
NUM_REQ, 2, number of requesters (only 2 required; arbiter is generic)

Ports:
clk  in  1  system clock; all state changes on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester operation request
req_ready  out  NUM_REQ  per-requester accept; at most one bit high
req_op  in  NUM_REQ*3  per-requester opcode (package enum)
req_src  in  NUM_REQ*RW  per-requester source register index
req_dst  in  NUM_REQ*RW  per-requester destination register index
done  out  1  one-cycle pulse: operation completed
err  out  1  one-cycle pulse: operation rejected
resp_id  out  clog2(NUM_REQ) max 1  requester index for done/err
l_tl_n  out  NUM_REGS  load low byte from main bus
l_th_n  out  NUM_REGS  load high byte from main bus
l_tx_n  out  NUM_REGS  load 16 bits from transfer bus
a_tl_n  out  NUM_REGS  assert low byte onto main bus
a_th_n  out  NUM_REGS  assert high byte onto main bus
a_tx_addr_n  out  NUM_REGS  assert register onto address bus
a_tx_xfer_n  out  NUM_REGS  assert register onto transfer bus

Behaviour:
- Reset (rst_n low at clock edge): state IDLE; every strobe output all-ones; done=0; err=0; resp_id=0; round-robin pointer=0.
- All strobes are registered; no combinational path from req_* to strobes.
- Opcodes:
  - MOVE (src->dst over transfer bus: a_tx_xfer_n[src], l_tx_n[dst])
  - LDL (main bus -> dst low: l_tl_n[dst])
  - LDH (l_th_n[dst])
  - STL (a_tl_n[src])
  - STH (a_th_n[src])
  - ADDR (a_tx_addr_n[src])
  - 2 codes reserved.
- req_ready: combinational. High only for the requester selected by the round-robin arbiter among valid requesters, and only while state==IDLE.
- Handshake: accept on the edge where req_valid[i]&req_ready[i]. req_* are sampled on that edge only; the requester may change them afterwards.
- The round-robin pointer moves to (granted+1) mod NUM_REQ on every accept, including rejected operations.
- FSM IDLE -> DRIVE -> HOLD -> IDLE:
  - DRIVE (1 cycle): the assert strobe (if any) and the load strobe (if any) are low.
  - HOLD (1 cycle): load strobe high (rising edge = latch); assert strobe stays low for hold time.
  - HOLD -> IDLE: all strobes high; done=1 and resp_id=granted during the first IDLE cycle.
- Latency: accept edge E → strobes low in cycle E+1 → load rises at E+2 → done in cycle E+3.
- Throughput: 1 op per 3 cycles. req_ready may be high in the same cycle done pulses.
- STL/STH/ADDR have no load strobe; their assert strobe is low for DRIVE+HOLD (2 cycles).
- LDL/LDH have no assert strobe; the main bus is driven externally, and the external source must keep it stable through HOLD.
- Rejection: a reserved opcode, any used index >= NUM_REGS, or MOVE with src==dst is still accepted, but the FSM stays in IDLE. No strobe toggles; err=1, resp_id=granted in the next cycle.
- Invariants: at most one bit low across the union of the a_tl_n/a_th_n vectors, and at most one low in a_tx_xfer_n and in a_tx_addr_n. At most one load strobe low in any cycle.
- Reset mid-operation: all strobes return high on the reset edge. If reset lands during DRIVE, the destination latches the then-current bus value (documented; caller discards). No done is emitted.
- No requests: outputs static, all strobes high.

Decomposition:
- Package xfer_pkg holds:
  - opcode enum xfer_op_t (MOVE, LDL, LDH, STL, STH, ADDR, RSV6, RSV7)
  - FSM enum xfer_state_t (IDLE, DRIVE, HOLD)
  - all-ones strobe constant helper
- Sub-module rr_arbiter (NUM_REQ param): inputs are the request vector, pointer and advance; outputs are a one-hot grant and the grant index.
- One-hot index decode to active-low vectors stays inline.

Test Plan:
- Reset: hold rst_n=0 3 cycles with req_valid=2'b11 → all strobes all-ones, req_ready=0, done=0. Release → requester 0 granted first.
- MOVE src=1 dst=2 from req 0, accepted at edge E:
  - a_tx_xfer_n=4'b1101 in E+1 and E+2
  - l_tx_n=4'b1011 in E+1 only
  - done=1, resp_id=0 in E+3
- Both requesters valid continuously (req0 STL src=0, req1 LDH dst=3) → grants alternate 0,1,0,1. Each op spaced 3 cycles; a_tl_n and l_th_n are never low in the same cycle.
- Errors: MOVE src=dst=2 → err=1 in cycle after accept, no strobe activity. Reserved opcode 6 → same. Pointer still advances.
- ADDR src=3 → a_tx_addr_n=4'b0111 for exactly 2 cycles, no load strobes, then done.
- rst_n=0 asserted during DRIVE of MOVE 0->1 → next cycle all strobes high, state IDLE, no done pulse.
